spi_ram_ctrl: RTL and testbench

Single-port synchronous RAM with a command decoder. It sits directly downstream of the SPI slave and consumes its 10-bit rx_data/rx_valid words. Each word is {cmd[1:0], payload[7:0]}. For read commands it returns 8-bit data on dout/tx_valid, which the SPI slave shifts out on MISO.

---
 rtl/spi_ram_ctrl.sv | 79 +++++++
 tb/tb_spi_ram_ctrl.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/spi_ram_ctrl.sv
// spi_ram_ctrl: command-decoded single-port RAM behind an SPI slave word stream
module spi_ram_ctrl #(
  parameter int MEM_DEPTH = 256,
  parameter int ADDR_SIZE = 8,
  parameter int AUTO_INC  = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] din,
  input  logic       rx_valid,
  output logic [7:0] dout,
  output logic       tx_valid,
  output logic       err
);
  localparam int IW = MEM_DEPTH > 1 ? $clog2(MEM_DEPTH) : 1;
  localparam logic [ADDR_SIZE:0] DEPTH = (ADDR_SIZE+1)'(MEM_DEPTH);
  localparam logic [ADDR_SIZE:0] ONE = (ADDR_SIZE+1)'(1);
  logic [7:0] mem [MEM_DEPTH];
  logic [ADDR_SIZE-1:0] wr_addr_q, wr_addr_d, rd_addr_q, rd_addr_d, wr_nxt, rd_nxt;
  logic [7:0] dout_q, dout_d;
  logic tx_valid_q, tx_valid_d, err_q, err_d, mem_we, wr_ok, rd_ok;
  logic [1:0] cmd;
  logic [7:0] payload;
  assign cmd = din[9:8];
  assign payload = din[7:0];
  assign wr_ok = {1'b0, wr_addr_q} < DEPTH;
  assign rd_ok = {1'b0, rd_addr_q} < DEPTH;
  assign wr_nxt = ADDR_SIZE'(({1'b0, wr_addr_q} + ONE) % DEPTH);
  assign rd_nxt = ADDR_SIZE'(({1'b0, rd_addr_q} + ONE) % DEPTH);
  assign dout = dout_q;
  assign tx_valid = tx_valid_q;
  assign err = err_q;
  // decode one accepted word into address updates, memory write and read response
  always_comb begin
    wr_addr_d = wr_addr_q;
    rd_addr_d = rd_addr_q;
    dout_d = dout_q;
    tx_valid_d = 1'b0;
    err_d = 1'b0;
    mem_we = 1'b0;
    if (rx_valid) begin
      case (cmd)
        2'b00: wr_addr_d = payload[ADDR_SIZE-1:0];
        2'b01: begin
          mem_we = wr_ok;
          err_d = !wr_ok;
          wr_addr_d = AUTO_INC != 0 ? wr_nxt : wr_addr_q;
        end
        2'b10: rd_addr_d = payload[ADDR_SIZE-1:0];
        default: begin
          tx_valid_d = 1'b1;
          dout_d = rd_ok ? mem[rd_addr_q[IW-1:0]] : 8'h00;
          err_d = !rd_ok;
          rd_addr_d = AUTO_INC != 0 ? rd_nxt : rd_addr_q;
        end
      endcase
    end
  end
  // control and output registers; a word arriving during reset is dropped
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_addr_q <= '0;
      rd_addr_q <= '0;
      dout_q <= 8'h00;
      tx_valid_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      wr_addr_q <= wr_addr_d;
      rd_addr_q <= rd_addr_d;
      dout_q <= dout_d;
      tx_valid_q <= tx_valid_d;
      err_q <= err_d;
    end
  end
  // storage array, deliberately left uncleared by reset
  always_ff @(posedge clk) begin
    if (!rst && mem_we) mem[wr_addr_q[IW-1:0]] <= payload;
  end
endmodule

// File: tb/tb_spi_ram_ctrl.sv
// tb_spi_ram_ctrl: three configurations driven by one word stream, checked against a reference model
module tb_spi_ram_ctrl;
  localparam int DEP [3] = '{256, 128, 4};
  localparam int INC [3] = '{0, 0, 1};
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic rx_valid = 1'b0;
  logic [9:0] din = '0;
  logic [7:0] dout_a [3];
  logic tx_a [3];
  logic err_a [3];
  int checks = 0;
  int errors = 0;
  int m_mem [3][256];
  bit m_known [3][256];
  int m_wa [3], m_ra [3], m_dout [3];
  bit m_dk [3], m_tx [3], m_err [3];

  always #5 clk = ~clk;

  spi_ram_ctrl #(.MEM_DEPTH(256), .ADDR_SIZE(8), .AUTO_INC(0)) u0 (
    .clk(clk), .rst(rst), .din(din), .rx_valid(rx_valid),
    .dout(dout_a[0]), .tx_valid(tx_a[0]), .err(err_a[0]));
  spi_ram_ctrl #(.MEM_DEPTH(128), .ADDR_SIZE(8), .AUTO_INC(0)) u1 (
    .clk(clk), .rst(rst), .din(din), .rx_valid(rx_valid),
    .dout(dout_a[1]), .tx_valid(tx_a[1]), .err(err_a[1]));
  spi_ram_ctrl #(.MEM_DEPTH(4), .ADDR_SIZE(8), .AUTO_INC(1)) u2 (
    .clk(clk), .rst(rst), .din(din), .rx_valid(rx_valid),
    .dout(dout_a[2]), .tx_valid(tx_a[2]), .err(err_a[2]));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model(input bit r, input bit v, input logic [9:0] d);
    int p;
    p = int'(d[7:0]);
    for (int i = 0; i < 3; i++) begin
      m_tx[i] = 0;
      m_err[i] = 0;
      if (r) begin
        m_wa[i] = 0; m_ra[i] = 0; m_dout[i] = 0; m_dk[i] = 1;
      end else if (v) begin
        case (d[9:8])
          2'b00: m_wa[i] = p;
          2'b01: begin
            if (m_wa[i] < DEP[i]) begin
              m_mem[i][m_wa[i]] = p;
              m_known[i][m_wa[i]] = 1;
            end else m_err[i] = 1;
            if (INC[i] != 0) m_wa[i] = (m_wa[i] + 1) % DEP[i];
          end
          2'b10: m_ra[i] = p;
          default: begin
            m_tx[i] = 1;
            if (m_ra[i] < DEP[i]) begin
              m_dout[i] = m_mem[i][m_ra[i]];
              m_dk[i] = m_known[i][m_ra[i]];
            end else begin
              m_dout[i] = 0; m_dk[i] = 1; m_err[i] = 1;
            end
            if (INC[i] != 0) m_ra[i] = (m_ra[i] + 1) % DEP[i];
          end
        endcase
      end
    end
  endtask

  task automatic step(input bit r, input bit v, input logic [9:0] d);
    rst = r;
    rx_valid = v;
    din = d;
    @(posedge clk);
    model(r, v, d);
    #1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("tx_valid%0d", i), 32'(tx_a[i]), 32'(m_tx[i]));
      chk($sformatf("err%0d", i), 32'(err_a[i]), 32'(m_err[i]));
      if (m_dk[i]) chk($sformatf("dout%0d", i), 32'(dout_a[i]), 32'(m_dout[i]));
    end
    rst = 1'b0;
    rx_valid = 1'b0;
  endtask

  task automatic w(input logic [1:0] c, input logic [7:0] p);
    step(0, 1, {c, p});
  endtask

  initial begin
    step(1, 0, '0);
    w(2'b00, 8'h00);
    w(2'b01, 8'h3C);
    step(1, 1, 10'b01_10101010);
    step(1, 1, 10'b01_10101010);
    chk("rst_dout", 32'(dout_a[0]), 32'h00);
    chk("rst_tx", 32'(tx_a[0]), 32'h0);
    w(2'b11, 8'h00);
    chk("rst_drop", 32'(dout_a[0]), 32'h3C);
    w(2'b00, 8'h12);
    w(2'b01, 8'hA5);
    w(2'b10, 8'h12);
    w(2'b11, 8'h00);
    chk("wr_rd", 32'(dout_a[0]), 32'hA5);
    step(0, 0, '0);
    chk("wr_rd_tx_once", 32'(tx_a[0]), 32'h0);
    chk("wr_rd_hold", 32'(dout_a[0]), 32'hA5);
    for (int i = 0; i < 100; i++) begin
      w(2'b00, 8'(i));
      w(2'b01, 8'(i) ^ 8'h5A);
    end
    w(2'b10, 8'h00);
    for (int i = 0; i < 100; i++) begin
      w(2'b10, 8'(i));
      w(2'b11, 8'h00);
      chk("sweep", 32'(dout_a[0]), 32'(8'(i) ^ 8'h5A));
      chk("sweep_err", 32'(err_a[0]), 32'h0);
    end
    w(2'b00, 8'h07);
    w(2'b01, 8'h77);
    w(2'b00, 8'h03);
    w(2'b10, 8'h07);
    w(2'b01, 8'h33);
    w(2'b11, 8'h00);
    chk("indep_rd7", 32'(dout_a[0]), 32'h77);
    w(2'b10, 8'h03);
    w(2'b11, 8'h00);
    chk("indep_rd3", 32'(dout_a[0]), 32'h33);
    w(2'b00, 8'h90);
    w(2'b01, 8'hFF);
    chk("oor_wr_err", 32'(err_a[1]), 32'h1);
    w(2'b10, 8'h90);
    w(2'b11, 8'h00);
    chk("oor_rd_dout", 32'(dout_a[1]), 32'h00);
    chk("oor_rd_err", 32'(err_a[1]), 32'h1);
    chk("oor_rd_tx", 32'(tx_a[1]), 32'h1);
    w(2'b00, 8'h03);
    w(2'b01, 8'h11);
    w(2'b01, 8'h22);
    w(2'b10, 8'h03);
    w(2'b11, 8'h00);
    chk("inc_rd3", 32'(dout_a[2]), 32'h11);
    w(2'b11, 8'h00);
    chk("inc_wrap", 32'(dout_a[2]), 32'h22);
    w(2'b10, 8'h03);
    w(2'b11, 8'h00);
    chk("inc_rd3b", 32'(dout_a[2]), 32'h11);
    step(1, 0, '0);
    w(2'b11, 8'h00);
    chk("inc_rst_rd0", 32'(dout_a[2]), 32'h22);
    for (int n = 0; n < 3000; n++) begin
      logic [1:0] c;
      logic [7:0] p;
      c = 2'($urandom_range(0, 3));
      p = $urandom_range(0, 1) != 0 ? 8'($urandom_range(0, 7)) : 8'($urandom);
      step($urandom_range(0, 99) < 2, $urandom_range(0, 3) != 0, {c, p});
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
